// File: rtl/tl_a_prot_echo_tracker_pkg.sv
// Shared prot echo types for the TileLink A-channel echo tracker.
// Holds the prot layout and its bit positions.
package tl_prot_pkg;

  localparam int PROT_W = 7;

  localparam int PROT_BUFFERABLE = 0;
  localparam int PROT_MODIFIABLE = 1;
  localparam int PROT_READALLOC  = 2;
  localparam int PROT_WRITEALLOC = 3;
  localparam int PROT_PRIVILEGED = 4;
  localparam int PROT_SECURE     = 5;
  localparam int PROT_FETCH      = 6;

  typedef struct packed {
    logic fetch;
    logic secure;
    logic privileged;
    logic writealloc;
    logic readalloc;
    logic modifiable;
    logic bufferable;
  } prot_t;

  function automatic prot_t to_prot(
    input logic [PROT_W-1:0] raw
  );
    return prot_t'(raw);
  endfunction

endpackage

// File: rtl/tl_a_prot_echo_tracker_if.sv
// Observed A/D channel signals plus the tracker's echo and error outputs.
// master drives the channels; slave is the tracker.
interface tl_a_prot_echo_tracker_if #(
  parameter int SOURCE_BITS = 2,
  parameter int PROT_W      = 7
);
  logic                   a_valid;
  logic                   a_ready;
  logic                   a_last;
  logic [SOURCE_BITS-1:0] a_source;
  logic [PROT_W-1:0]      a_prot;
  logic                   d_valid;
  logic                   d_ready;
  logic                   d_last;
  logic [SOURCE_BITS-1:0] d_source;
  logic [PROT_W-1:0]      d_prot;
  logic                   d_prot_valid;
  logic [SOURCE_BITS:0]   inflight_cnt;
  logic                   err_dup_source;
  logic                   err_orphan_d;
  logic                   err_prot_change;

  modport master (
    output a_valid, a_ready, a_last,
    output a_source, a_prot,
    output d_valid, d_ready, d_last,
    output d_source,
    input  d_prot, d_prot_valid,
    input  inflight_cnt,
    input  err_dup_source, err_orphan_d,
    input  err_prot_change
  );

  modport slave (
    input  a_valid, a_ready, a_last,
    input  a_source, a_prot,
    input  d_valid, d_ready, d_last,
    input  d_source,
    output d_prot, d_prot_valid,
    output inflight_cnt,
    output err_dup_source, err_orphan_d,
    output err_prot_change
  );
endinterface

// File: rtl/tl_a_prot_echo_tracker_table.sv
// Per-source {vld, prot} store: one alloc port, one clear port, one read port.
// Alloc overrides a same-entry clear in the same cycle.
module tl_echo_table
  import tl_prot_pkg::*;
#(
  parameter int SB = 2,
  parameter int PW = PROT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_i,
  input  logic [SB-1:0]        alloc_idx_i,
  input  logic [PW-1:0]        alloc_prot_i,
  input  logic                 rel_i,
  input  logic [SB-1:0]        rel_idx_i,
  input  logic [SB-1:0]        rd_idx_i,
  output logic [PW-1:0]        rd_prot_o,
  output logic                 rd_vld_o,
  output logic [(1<<SB)-1:0]   vld_o
);
  localparam int N = 1 << SB;

  logic [N-1:0]  vld_q, vld_d;
  logic [PW-1:0] prot_q [N];
  logic [PW-1:0] prot_d [N];

  always_comb begin
    vld_d  = vld_q;
    prot_d = prot_q;
    if (rel_i) vld_d[rel_idx_i] = 1'b0;
    if (alloc_i) begin
      vld_d[alloc_idx_i]  = 1'b1;
      prot_d[alloc_idx_i] = alloc_prot_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < N; i++) prot_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      prot_q <= prot_d;
    end
  end

  assign rd_prot_o = prot_q[rd_idx_i];
  assign rd_vld_o  = vld_q[rd_idx_i];
  assign vld_o     = vld_q;
endmodule

// File: rtl/tl_a_prot_echo_tracker.sv
// Captures A-channel prot per source and echoes it beside the D response.
// Also flags duplicate sources, orphan responses and mid-burst prot changes.
module tl_a_prot_echo_tracker
  import tl_prot_pkg::*;
#(
  parameter int SOURCE_BITS = 2,
  parameter int PW          = PROT_W
) (
  input logic clock,
  input logic reset,
  tl_a_prot_echo_tracker_if.slave bus
);
  logic [(1<<SOURCE_BITS)-1:0] vld;
  logic [PW-1:0]        first_prot_q, first_prot_d;
  logic [SOURCE_BITS:0] cnt_q, cnt_d;
  logic a_first_q, a_first_d;
  logic dup_q, dup_d;
  logic orph_q, orph_d;
  logic pchg_q, pchg_d;
  logic a_fire, d_fire, alloc, rel;
  logic same_src, inc, dec;
  logic d_vld;

  assign a_fire   = bus.a_valid & bus.a_ready;
  assign d_fire   = bus.d_valid & bus.d_ready;
  assign alloc    = a_fire & a_first_q;
  assign rel      = d_fire & bus.d_last & d_vld;
  assign same_src = bus.a_source == bus.d_source;

  tl_echo_table #(
    .SB (SOURCE_BITS),
    .PW (PW)
  ) u_table (
    .clk_i        (clock),
    .rst_i        (reset),
    .alloc_i      (alloc),
    .alloc_idx_i  (bus.a_source),
    .alloc_prot_i (bus.a_prot),
    .rel_i        (rel),
    .rel_idx_i    (bus.d_source),
    .rd_idx_i     (bus.d_source),
    .rd_prot_o    (bus.d_prot),
    .rd_vld_o     (d_vld),
    .vld_o        (vld)
  );

  always_comb begin
    a_first_d    = a_first_q;
    first_prot_d = first_prot_q;
    if (a_fire) a_first_d = bus.a_last;
    if (alloc) first_prot_d = bus.a_prot;
    // A release of the same entry this cycle makes the reuse legal.
    dup_d  = alloc & vld[bus.a_source] & ~(rel & same_src);
    orph_d = d_fire & ~d_vld;
    pchg_d = a_fire & ~a_first_q &
             (bus.a_prot != first_prot_q);
    inc = alloc & ~vld[bus.a_source];
    dec = rel & ~(alloc & same_src);
    cnt_d = cnt_q;
    unique case ({inc, dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_first_q    <= 1'b1;
      first_prot_q <= '0;
      cnt_q        <= '0;
      dup_q        <= 1'b0;
      orph_q       <= 1'b0;
      pchg_q       <= 1'b0;
    end else begin
      a_first_q    <= a_first_d;
      first_prot_q <= first_prot_d;
      cnt_q        <= cnt_d;
      dup_q        <= dup_d;
      orph_q       <= orph_d;
      pchg_q       <= pchg_d;
    end
  end

  assign bus.d_prot_valid    = d_vld;
  assign bus.inflight_cnt    = cnt_q;
  assign bus.err_dup_source  = dup_q;
  assign bus.err_orphan_d    = orph_q;
  assign bus.err_prot_change = pchg_q;
endmodule

// File: tb/tb_tl_a_prot_echo_tracker.sv
// Directed vector bench for the prot echo tracker.
// Each row: inputs, pre-edge echo expectation, post-edge count/error expectation.
module tb_tl_a_prot_echo_tracker;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tl_a_prot_echo_tracker_if #(.SOURCE_BITS(2), .PROT_W(7)) bus ();

  tl_a_prot_echo_tracker #(.SOURCE_BITS(2), .PW(7)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       av, ar, al;
    logic [1:0] as;
    logic [6:0] ap;
    logic       dv, dr, dl;
    logic [1:0] ds;
    logic       cp;
    logic [6:0] ep;
    logic       epv;
    logic [2:0] ec;
    logic       edup, eorp, epc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic av, ar, al, input logic [1:0] as, input logic [6:0] ap,
    input logic dv, dr, dl, input logic [1:0] ds,
    input logic cp, input logic [6:0] ep, input logic epv,
    input logic [2:0] ec, input logic edup, eorp, epc);
    vec_t v;
    v.av = av; v.ar = ar; v.al = al; v.as = as; v.ap = ap;
    v.dv = dv; v.dr = dr; v.dl = dl; v.ds = ds;
    v.cp = cp; v.ep = ep; v.epv = epv;
    v.ec = ec; v.edup = edup; v.eorp = eorp; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a_valid = v.av; bus.a_ready = v.ar; bus.a_last = v.al;
    bus.a_source = v.as; bus.a_prot = v.ap;
    bus.d_valid = v.dv; bus.d_ready = v.dr; bus.d_last = v.dl;
    bus.d_source = v.ds;
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #4;
    chk("d_prot_valid", idx, 32'(bus.d_prot_valid), 32'(v.epv));
    if (v.cp) chk("d_prot", idx, 32'(bus.d_prot), 32'(v.ep));
    @(posedge clk);
    #1;
    chk("inflight_cnt", idx, 32'(bus.inflight_cnt), 32'(v.ec));
    chk("err_dup", idx, 32'(bus.err_dup_source), 32'(v.edup));
    chk("err_orphan", idx, 32'(bus.err_orphan_d), 32'(v.eorp));
    chk("err_pchg", idx, 32'(bus.err_prot_change), 32'(v.epc));
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,2'd0,7'h00, 0,0,0,2'd0, 0,7'h00,0, 3'd0,0,0,0);
    rst = 1'b1;
    drive(idle);

    // single beat source 2
    vq.push_back(mk(0,0,0,0,7'h00, 0,0,0,0, 1,7'h00,0, 0,0,0,0));
    vq.push_back(mk(1,1,1,2,7'h25, 0,0,0,2, 1,7'h00,0, 1,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,1,2, 1,7'h25,1, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 0,0,0,2, 0,7'h00,0, 0,0,0,0));
    // fill all four sources
    vq.push_back(mk(1,1,1,0,7'h01, 0,0,0,0, 1,7'h00,0, 1,0,0,0));
    vq.push_back(mk(1,1,1,1,7'h02, 0,0,0,0, 1,7'h01,1, 2,0,0,0));
    vq.push_back(mk(1,1,1,2,7'h04, 0,0,0,0, 1,7'h01,1, 3,0,0,0));
    vq.push_back(mk(1,1,1,3,7'h08, 0,0,0,0, 1,7'h01,1, 4,0,0,0));
    // valid without ready must not fire
    vq.push_back(mk(1,0,1,1,7'h7f, 0,0,0,1, 1,7'h02,1, 4,0,0,0));
    // release 3,1,0,2
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,1,3, 1,7'h08,1, 3,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,1,1, 1,7'h02,1, 2,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,1,0, 1,7'h01,1, 1,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,1,2, 1,7'h04,1, 0,0,0,0));
    // duplicate source 1
    vq.push_back(mk(1,1,1,1,7'h11, 0,0,0,1, 0,7'h00,0, 1,0,0,0));
    vq.push_back(mk(1,1,1,1,7'h22, 0,0,0,1, 1,7'h11,1, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 0,0,0,1, 1,7'h22,1, 1,0,0,0));
    // orphan D, last beat and non-last beat
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,1,3, 1,7'h08,0, 1,0,1,0));
    vq.push_back(mk(0,0,0,0,7'h00, 0,0,0,3, 0,7'h00,0, 1,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,0,2, 0,7'h00,0, 1,0,1,0));
    vq.push_back(mk(0,0,0,0,7'h00, 0,0,0,2, 0,7'h00,0, 1,0,0,0));
    // same-cycle alloc and release on source 0
    vq.push_back(mk(1,1,1,0,7'h03, 0,0,0,0, 0,7'h00,0, 2,0,0,0));
    vq.push_back(mk(1,1,1,0,7'h10, 1,1,1,0, 1,7'h03,1, 2,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 0,0,0,0, 1,7'h10,1, 2,0,0,0));
    // multi-beat D on source 0
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,0,0, 1,7'h10,1, 2,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,1,0, 1,7'h10,1, 1,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 0,0,0,0, 0,7'h00,0, 1,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 1,1,1,1, 1,7'h22,1, 0,0,0,0));
    // 4-beat burst on source 3, prot changes on beat 3
    vq.push_back(mk(1,1,0,3,7'h05, 0,0,0,3, 0,7'h00,0, 1,0,0,0));
    vq.push_back(mk(1,1,0,3,7'h05, 0,0,0,3, 1,7'h05,1, 1,0,0,0));
    vq.push_back(mk(1,1,0,3,7'h06, 0,0,0,3, 1,7'h05,1, 1,0,0,1));
    vq.push_back(mk(1,1,1,3,7'h05, 0,0,0,3, 1,7'h05,1, 1,0,0,0));
    vq.push_back(mk(0,0,0,0,7'h00, 0,0,0,3, 1,7'h05,1, 1,0,0,0));
    // next A after the burst is a first beat again
    vq.push_back(mk(1,1,1,2,7'h09, 0,0,0,2, 0,7'h00,0, 2,0,0,0));
    // start a burst on source 1 that reset will cut short
    vq.push_back(mk(1,1,0,1,7'h0a, 0,0,0,2, 1,7'h09,1, 3,0,0,0));
    vq.push_back(mk(1,1,0,1,7'h0a, 0,0,0,1, 1,7'h0a,1, 3,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", -1, 32'(bus.inflight_cnt), 32'd0);
    chk("rst_dup", -1, 32'(bus.err_dup_source), 32'd0);
    chk("rst_orphan", -1, 32'(bus.err_orphan_d), 32'd0);
    chk("rst_pchg", -1, 32'(bus.err_prot_change), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) step(vq[i], i);

    // asynchronous reset in the middle of the burst
    #2;
    drive(idle);
    bus.d_source = 2'd2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", 100, 32'(bus.inflight_cnt), 32'd0);
    chk("mid_rst_vld", 100, 32'(bus.d_prot_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(mk(1,1,1,1,7'h0c, 0,0,0,1, 1,7'h00,0, 1,0,0,0), 101);
    step(mk(0,0,0,0,7'h00, 0,0,0,1, 1,7'h0c,1, 1,0,0,0), 102);
    step(mk(0,0,0,0,7'h00, 0,0,0,3, 1,7'h00,0, 1,0,0,0), 103);
    step(mk(0,0,0,0,7'h00, 0,0,0,2, 1,7'h00,0, 1,0,0,0), 104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tl_a_prot_echo_tracker.md
Name: tl_a_prot_echo_tracker

Overview:
- Sits on the data-cache TileLink port, beside the A-channel prot echo field.
- On each A request it captures the AMBA prot echo and stores it per source ID.
- It returns that echo alongside the matching D response, so D-side consumers see the request's prot attributes without carrying them in flight.
- It also flags protocol violations: duplicate source, orphan response, and prot changing mid-burst.

Parameters:
- SOURCE_BITS, 2, width of a_source/d_source; the table holds 2**SOURCE_BITS entries.
- PROT_W, 7, prot echo width: {fetch, secure, privileged, writealloc, readalloc, modifiable, bufferable}.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_valid  input  1  A-channel valid (observed, not driven).
- a_ready  input  1  A-channel ready (observed).
- a_last  input  1  asserted on the final beat of the current A message.
- a_source  input  SOURCE_BITS  A source ID.
- a_prot  input  PROT_W  A prot echo field.
- d_valid  input  1  D-channel valid (observed).
- d_ready  input  1  D-channel ready (observed).
- d_last  input  1  asserted on the final beat of the current D message.
- d_source  input  SOURCE_BITS  D source ID.
- d_prot  output  PROT_W  echoed prot for d_source.
- d_prot_valid  output  1  the d_source entry is in flight.
- inflight_cnt  output  SOURCE_BITS+1  number of in-flight entries.
- err_dup_source  output  1  one-cycle pulse: A first beat fired on a source already in flight.
- err_orphan_d  output  1  one-cycle pulse: D fired on a source not in flight.
- err_prot_change  output  1  one-cycle pulse: a_prot differs from the first beat within one A burst.

Behaviour:
- Definitions: a_fire = a_valid & a_ready; d_fire = d_valid & d_ready.
- a_first register:
  - Reset value 1.
  - On a_fire it loads a_last.
  - The first beat of a burst is a_fire & a_first.
- first_prot register:
  - Holds a_prot of the first beat.
  - On a_fire & ~a_first & (a_prot != first_prot), err_prot_change pulses the next cycle.
- Table entry i holds {vld[i], prot[i]}. Reset clears all vld to 0 and prot to 0.
- Allocate: on an A first beat, at the next edge set vld[a_source]=1 and prot[a_source]=a_prot.
- Release: on d_fire & d_last, at the next edge clear vld[d_source].
- Same source, same cycle (A first beat and D last fire): release and allocate both apply.
  - Allocate wins: vld=1 and prot=new value.
  - No error is raised.
- err_dup_source: an A first beat on a source with vld=1, unless that same entry is being released in the same cycle.
  - The entry is still overwritten with the new prot.
- err_orphan_d: d_fire with vld[d_source]=0, on any beat.
  - Nothing is released.
- D lookup is combinational with zero latency: d_prot = prot[d_source], d_prot_valid = vld[d_source].
  - A same-cycle allocation is not visible until the next cycle.
- Multi-beat D: every beat sees the same echo; only the last beat releases.
- inflight_cnt:
  - Registered; increments on allocate of a non-valid entry.
  - Decrements on a valid release that is not re-allocated in the same cycle.
  - Equals the population count of vld at all times.
  - Cannot overflow, because the table is full at 2**SOURCE_BITS entries.
- Error outputs: registered, reset to 0, one-cycle pulses, and they may assert simultaneously.
- The block never stalls or modifies the channels; it is a pure observer plus echo source.
- Reset mid-burst clears all state immediately (asynchronously).
  - a_first returns to 1; beats after reset are treated as a new first beat.

Decomposition:
- Shared package tl_prot_pkg holds:
  - PROT_W;
  - the prot_t packed struct with fields fetch, secure, privileged, writealloc, readalloc, modifiable, bufferable;
  - bit-index constants.
- One natural sub-module, tl_echo_table:
  - The vld/prot register array with one write port (alloc), one clear port (release) and one combinational read port.
  - Allocate-over-release priority lives there.
- Burst tracking, error detection and the counter stay in the top level.

Test Plan:
- Single-beat A, source 2, prot 7'h25, then single-beat D source 2 -> during D: d_prot=7'h25, d_prot_valid=1; after D: inflight_cnt 1->0, no errors.
- Four sources allocated with prot 7'h01/02/04/08, released in order 3,1,0,2 -> each D echoes its own value; inflight_cnt goes 4,3,2,1,0.
- A on source 1 while source 1 is in flight -> err_dup_source pulses exactly one cycle; entry 1 holds the new prot; inflight_cnt unchanged.
- D fire on idle source 3 -> err_orphan_d=1 for one cycle; d_prot_valid=0; inflight_cnt unchanged.
- Same cycle: A first beat on source 0 (prot 7'h10) and D last beat on source 0 (old prot 7'h03) -> d_prot=7'h03 that cycle; next cycle vld[0]=1, prot=7'h10; no error; count unchanged.
- 4-beat A burst with prot changing on beat 3 -> err_prot_change once, and the table keeps the beat-1 prot. A separate test asserts reset after beat 2 of a burst, then sends a fresh beat -> that beat is allocated as a first beat and all prior entries are cleared.
